// File: rtl/valid_ready_pack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : valid_ready_pack_pkg
//  Description : Shared defaults, lane-counter width helper and output-register
//                state encoding for the valid/ready beat packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package valid_ready_pack_pkg;

    // Default input beat width in bits
    localparam int VRP_N_DEFAULT     = 4;
    // Default number of input beats per packed output word
    localparam int VRP_RATIO_DEFAULT = 4;
    // Lane-counter width for the default ratio
    localparam int VRP_CNT_W_DEFAULT = $clog2(VRP_RATIO_DEFAULT);

    // Lane-counter width for an arbitrary ratio (ratio is always >= 2)
    function automatic int vrp_cnt_width(input int ratio);
        return $clog2(ratio);
    endfunction

    // Output register occupancy
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } vrp_state_e;

endpackage : valid_ready_pack_pkg
`default_nettype wire

// File: rtl/valid_ready_pack.sv
`default_nettype none
// ============================================================================
//  Module      : valid_ready_pack
//  Description : Packs RATIO narrow N-bit beats into one N*RATIO-bit word.
//                Beats fill lanes LSB-first; dwn_last closes a word early and
//                up_keep marks which lanes carry data. The output is a single
//                register stage with one-cycle latency and full throughput.
//  Revision    : 1.0 - initial release
// ============================================================================
module valid_ready_pack
    import valid_ready_pack_pkg::*;
#(
    parameter int N     = VRP_N_DEFAULT,
    parameter int RATIO = VRP_RATIO_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dwn_vld,
    input  logic [N-1:0]         dwn_data,
    input  logic                 dwn_last,
    output logic                 dwn_rdy,
    output logic                 up_vld,
    output logic [N*RATIO-1:0]   up_data,
    output logic [RATIO-1:0]     up_keep,
    output logic                 up_last,
    input  logic                 up_rdy
);

    localparam int               CNT_W   = vrp_cnt_width(RATIO);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

    // Lane counter and partially assembled word
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N*RATIO-1:0] asm_q, asm_d;

    // Output register
    vrp_state_e         state_q;
    logic [N*RATIO-1:0] up_data_q;
    logic [RATIO-1:0]   up_keep_q;
    logic               up_last_q;

    // Handshake decode and the word as it looks with the current beat merged
    logic               w_accept;
    logic               w_complete;
    logic [N*RATIO-1:0] w_word;
    logic [RATIO-1:0]   w_keep;

    // Ready depends only on the output register and up_rdy, never on dwn_*
    assign up_vld  = (state_q == ST_FULL);
    assign dwn_rdy = ~up_vld | up_rdy;
    assign up_data = up_data_q;
    assign up_keep = up_keep_q;
    assign up_last = up_last_q;

    // Merge the incoming beat into lane cnt and compute next counter/buffer
    always_comb begin
        w_accept   = dwn_vld & dwn_rdy;
        w_complete = w_accept & (dwn_last | (cnt_q == CNT_MAX));
        w_word     = asm_q;
        w_keep     = '0;
        for (int l = 0; l < RATIO; l++) begin
            if (CNT_W'(l) == cnt_q) begin
                w_word[l*N +: N] = dwn_data;
            end
            if (CNT_W'(l) <= cnt_q) begin
                w_keep[l] = 1'b1;
            end
        end

        cnt_d = cnt_q;
        asm_d = asm_q;
        if (w_complete) begin
            // Word handed to the output register; start the next one clean
            cnt_d = '0;
            asm_d = '0;
        end else if (w_accept) begin
            cnt_d = cnt_q + CNT_W'(1);
            asm_d = w_word;
        end
    end

    // Lane counter and assembly buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
        end
    end

    // Output register EMPTY/FULL machine; a completing beat always reloads it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            up_data_q <= '0;
            up_keep_q <= '0;
            up_last_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_complete) begin
                        state_q   <= ST_FULL;
                        up_data_q <= w_word;
                        up_keep_q <= w_keep;
                        up_last_q <= dwn_last;
                    end
                end
                ST_FULL: begin
                    if (w_complete) begin
                        // Only reachable with up_rdy=1: old word leaves, new one lands
                        state_q   <= ST_FULL;
                        up_data_q <= w_word;
                        up_keep_q <= w_keep;
                        up_last_q <= dwn_last;
                    end else if (up_rdy) begin
                        state_q   <= ST_EMPTY;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule : valid_ready_pack
`default_nettype wire

// File: tb/tb_valid_ready_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_valid_ready_pack
//  Description : Directed self-checking bench for valid_ready_pack (N=4,
//                RATIO=4) with hand-computed expected words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_valid_ready_pack;

    logic        clk;
    logic        rst_n;
    logic        dwn_vld;
    logic [3:0]  dwn_data;
    logic        dwn_last;
    logic        dwn_rdy;
    logic        up_vld;
    logic [15:0] up_data;
    logic [3:0]  up_keep;
    logic        up_last;
    logic        up_rdy;

    int n_tests;
    int n_fail;

    valid_ready_pack #(
        .N     (4),
        .RATIO (4)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dwn_vld  (dwn_vld),
        .dwn_data (dwn_data),
        .dwn_last (dwn_last),
        .dwn_rdy  (dwn_rdy),
        .up_vld   (up_vld),
        .up_data  (up_data),
        .up_keep  (up_keep),
        .up_last  (up_last),
        .up_rdy   (up_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one beat, wait for the edge, leave the beat on the bus
    task automatic beat(input logic [3:0] d, input logic l);
        dwn_vld  = 1'b1;
        dwn_data = d;
        dwn_last = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dwn_vld  = 1'b0;
        dwn_data = 4'h0;
        dwn_last = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        clk      = 1'b0;
        rst_n    = 1'b1;
        dwn_vld  = 1'b0;
        dwn_data = 4'h0;
        dwn_last = 1'b0;
        up_rdy   = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_up_vld",  32'(up_vld),  32'h0);
        chk("rst_up_data", 32'(up_data), 32'h0);
        chk("rst_up_keep", 32'(up_keep), 32'h0);
        chk("rst_up_last", 32'(up_last), 32'h0);
        chk("rst_dwn_rdy", 32'(dwn_rdy), 32'h1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Full word 1,2,3,4
        beat(4'h1, 1'b0);
        chk("w1_vld_b1", 32'(up_vld), 32'h0);
        beat(4'h2, 1'b0);
        beat(4'h3, 1'b0);
        chk("w1_vld_b3", 32'(up_vld), 32'h0);
        beat(4'h4, 1'b0);
        chk("w1_vld",  32'(up_vld),  32'h1);
        chk("w1_data", 32'(up_data), 32'h4321);
        chk("w1_keep", 32'(up_keep), 32'hF);
        chk("w1_last", 32'(up_last), 32'h0);
        idle();
        chk("w1_vld_pulse", 32'(up_vld), 32'h0);

        // Early close after two beats
        beat(4'hA, 1'b0);
        beat(4'hB, 1'b1);
        chk("w2_vld",  32'(up_vld),  32'h1);
        chk("w2_data", 32'(up_data), 32'h00BA);
        chk("w2_keep", 32'(up_keep), 32'h3);
        chk("w2_last", 32'(up_last), 32'h1);
        idle();
        // Last on first beat: lane 0 only, proves counter restarted
        beat(4'hC, 1'b1);
        chk("w3_data", 32'(up_data), 32'h000C);
        chk("w3_keep", 32'(up_keep), 32'h1);
        chk("w3_last", 32'(up_last), 32'h1);
        idle();

        // Backpressure: hold the word 5 cycles while a beat is offered
        up_rdy = 1'b0;
        beat(4'h1, 1'b0);
        beat(4'h2, 1'b0);
        beat(4'h3, 1'b0);
        beat(4'h4, 1'b0);
        chk("bp_vld", 32'(up_vld), 32'h1);
        dwn_data = 4'h9;
        dwn_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_dwn_rdy", 32'(dwn_rdy), 32'h0);
            chk("bp_data",    32'(up_data), 32'h4321);
            chk("bp_vld_hold", 32'(up_vld), 32'h1);
            @(posedge clk);
            #1;
        end
        up_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(dwn_rdy), 32'h1);
        @(posedge clk);
        #1;
        chk("bp_pop_vld", 32'(up_vld), 32'h0);
        beat(4'hA, 1'b0);
        beat(4'hB, 1'b0);
        beat(4'hC, 1'b0);
        chk("bp_next_data", 32'(up_data), 32'hCBA9);
        chk("bp_next_keep", 32'(up_keep), 32'hF);
        idle();

        // Eight continuous beats with up_rdy held high
        for (int i = 1; i <= 8; i++) begin
            dwn_vld  = 1'b1;
            dwn_data = 4'(i);
            dwn_last = 1'b0;
            #1;
            chk("cont_dwn_rdy", 32'(dwn_rdy), 32'h1);
            @(posedge clk);
            #1;
            if (i == 4) chk("cont_w1", 32'(up_data), 32'h4321);
            if (i == 4 || i == 8) chk("cont_vld_hi", 32'(up_vld), 32'h1);
            if (i == 5 || i == 7) chk("cont_vld_lo", 32'(up_vld), 32'h0);
            if (i == 8) chk("cont_w2", 32'(up_data), 32'h8765);
        end
        idle();

        // Back-to-back single-beat words: FULL reloads with no gap
        beat(4'h5, 1'b1);
        chk("b2b_w1", 32'(up_data), 32'h0005);
        beat(4'h6, 1'b1);
        chk("b2b_vld", 32'(up_vld),  32'h1);
        chk("b2b_w2",  32'(up_data), 32'h0006);
        chk("b2b_keep", 32'(up_keep), 32'h1);
        idle();
        chk("b2b_no_dup", 32'(up_vld), 32'h0);

        // Reset mid-word discards the partial beats
        beat(4'h1, 1'b0);
        beat(4'h2, 1'b0);
        dwn_vld = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(up_vld), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_rst_vld2", 32'(up_vld), 32'h0);
        rst_n = 1'b1;
        beat(4'h5, 1'b0);
        beat(4'h6, 1'b0);
        beat(4'h7, 1'b0);
        chk("post_rst_early", 32'(up_vld), 32'h0);
        beat(4'h8, 1'b0);
        chk("post_rst_vld",  32'(up_vld),  32'h1);
        chk("post_rst_data", 32'(up_data), 32'h8765);
        chk("post_rst_keep", 32'(up_keep), 32'hF);
        idle();
        chk("post_rst_single", 32'(up_vld), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_valid_ready_pack
`default_nettype wire

// File: doc/valid_ready_pack.md
VALID_READY_PACK -- requirements
Module: valid_ready_pack

Interface
REQ-001 SHALL have parameter N, default 4, meaning input beat width in bits.
REQ-002 SHALL have parameter RATIO, default 4, meaning input beats per output word; RATIO >= 2.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port dwn_vld, input, 1 bit, meaning an input beat is offered.
REQ-006 SHALL have port dwn_data, input, N bits, meaning the input beat payload.
REQ-007 SHALL have port dwn_last, input, 1 bit, meaning the beat closes the current word early.
REQ-008 SHALL have port dwn_rdy, output, 1 bit, meaning the block accepts a beat this cycle.
REQ-009 SHALL have port up_vld, output, 1 bit, meaning a packed word is offered.
REQ-010 SHALL have port up_data, output, N*RATIO bits, meaning the packed word.
REQ-011 SHALL have port up_keep, output, RATIO bits, meaning one bit per lane that holds a valid beat.
REQ-012 SHALL have port up_last, output, 1 bit, meaning the word was closed by dwn_last.
REQ-013 SHALL have port up_rdy, input, 1 bit, meaning the consumer accepts the word.

Function
REQ-014 SHALL accept a beat exactly when dwn_vld & dwn_rdy at a rising edge.
REQ-015 SHALL drive dwn_rdy = ~up_vld | up_rdy, with no combinational path from dwn_vld, dwn_data or dwn_last.
REQ-016 SHALL hold lane counter cnt (0..RATIO-1) and place each accepted beat in lane cnt, i.e. bits [cnt*N +: N]; the first beat goes to the LSBs.
REQ-017 SHALL treat an accepted beat as completing when cnt == RATIO-1 or dwn_last == 1.
REQ-018 On a non-completing accept, SHALL store the beat in the assembly buffer and set cnt to cnt+1.
REQ-019 On a completing accept, SHALL load the output register at that edge: up_data = assembled lanes plus this beat, unfilled lanes 0; up_keep = ones in lanes 0..cnt; up_last = dwn_last; up_vld = 1. SHALL then set cnt to 0 and clear the assembly buffer.
REQ-020 Latency SHALL be one cycle: up_vld is high in the cycle after the completing accept.
REQ-021 Output register states SHALL be EMPTY (up_vld=0) and FULL (up_vld=1).
REQ-022 Transition EMPTY->FULL SHALL occur on a completing accept.
REQ-023 Transition FULL->EMPTY SHALL occur when up_rdy=1 and there is no completing accept.
REQ-024 FULL SHALL remain FULL with the new word loaded when up_rdy=1 and a completing accept occur in the same cycle.
REQ-025 While up_vld & ~up_rdy, up_data, up_keep and up_last SHALL stay stable and dwn_rdy SHALL be 0.
REQ-026 With up_rdy held 1, SHALL sustain one accepted beat per cycle indefinitely.
REQ-027 dwn_last with cnt == RATIO-1 SHALL produce a full word (up_keep all ones) with up_last=1.
REQ-028 dwn_last on the first beat SHALL produce up_keep = 1 in lane 0 only.

Reset
REQ-029 While rst_n=0, SHALL force up_vld=0, up_data=0, up_keep=0, up_last=0, cnt=0, and assembly buffer=0; dwn_rdy therefore reads 1.
REQ-030 Reset asserted mid-word SHALL discard the partial word; the first accept after release SHALL go to lane 0.

Structure
REQ-031 Defaults for N and RATIO, and the lane-counter width $clog2(RATIO), SHALL live in the shared package header.
REQ-032 SHALL be a single module with no sub-modules; the counter, assembly buffer and output register are inline.

Verification
REQ-033 N=4, RATIO=4, up_rdy=1, beats 0x1,0x2,0x3,0x4 back-to-back -> one cycle later up_data=0x4321, up_keep=4'b1111, up_last=0, up_vld high for exactly 1 cycle.
REQ-034 Beats 0xA, then 0xB with dwn_last=1 -> up_data=0x00BA, up_keep=4'b0011, up_last=1; the next beat lands in lane 0.
REQ-035 Word held with up_rdy=0 for 5 cycles while dwn_vld=1 -> dwn_rdy=0, up_data stable, no beats accepted; when up_rdy returns to 1, dwn_rdy=1 in the same cycle.
REQ-036 8 continuous beats 0x1..0x8, up_rdy=1 -> words 0x4321 then 0x8765 on consecutive-word cycles, and dwn_rdy never drops.
REQ-037 Accept 0x1,0x2, pulse rst_n low, release, send 0x5..0x8 -> up_vld=0 during reset, then a single word 0x8765 with up_keep=4'b1111.
REQ-038 up_vld=1, up_rdy=1 and a completing accept in the same cycle -> up_vld stays 1 and the new word replaces the old, with no gap and no duplicate.
